// File: rtl/uart_sim_receiver_pkg.sv
// Shared types and constants for the 8N1 oversampling UART receiver.
package uart_sim_receiver_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  MID_SAMPLE = 4'd8;
  localparam logic [3:0]  FRAME_BITS = 4'd8;

  typedef enum logic [1:0] {
    START = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/uart_sim_receiver.sv
// 8N1 UART receiver: 16x oversampling on clken ticks, mid-bit data sampling,
// sticky rdy flag cleared by rdy_clr.
module uart_sim_receiver
  import uart_sim_receiver_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       clken,
  input  logic       rx,
  output logic       rdy,
  input  logic       rdy_clr,
  output logic [7:0] data
);

  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

  rx_state_t  state_q, state_d;
  logic [3:0] sample_q, sample_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] scratch_q, scratch_d;
  logic [7:0] data_q, data_d;
  logic       rdy_q, rdy_d;

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    bit_d     = bit_q;
    scratch_d = scratch_q;
    data_d    = data_q;
    // Clearing is not gated by clken; a completing byte below overrides it.
    rdy_d     = rdy_q & ~rdy_clr;

    if (clken) begin
      unique case (state_q)
        START: begin
          if (!(rx && (sample_q == 4'd0))) begin
            sample_d = sample_q + 4'd1;
          end
          if (sample_q == LAST_SAMPLE) begin
            state_d   = DATA;
            sample_d  = '0;
            bit_d     = '0;
            scratch_d = '0;
          end
        end

        DATA: begin
          sample_d = sample_q + 4'd1;
          if ((sample_q == MID_SAMPLE) && (bit_q < FRAME_BITS)) begin
            scratch_d[bit_q[2:0]] = rx;
            bit_d                 = bit_q + 4'd1;
          end
          if ((bit_q == FRAME_BITS) && (sample_q == LAST_SAMPLE)) begin
            state_d = STOP;
          end
        end

        STOP: begin
          // Early exit on a low line after mid-stop lets back-to-back frames resync.
          if ((sample_q == LAST_SAMPLE) || ((sample_q >= MID_SAMPLE) && !rx)) begin
            state_d  = START;
            sample_d = '0;
            data_d   = scratch_q;
            rdy_d    = 1'b1;
          end else begin
            sample_d = sample_q + 4'd1;
          end
        end

        default: begin
          state_d  = START;
          sample_d = '0;
          bit_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q   <= START;
      sample_q  <= '0;
      bit_q     <= '0;
      scratch_q <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      bit_q     <= bit_d;
      scratch_q <= scratch_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
    end
  end

  assign rdy  = rdy_q;
  assign data = data_q;

endmodule

// File: tb/tb_uart_sim_receiver.sv
// Scoreboard bench for uart_sim_receiver: directed frames, expected bytes queued
// at send time and popped by a monitor whenever a new byte is presented.
module tb_uart_sim_receiver;

  logic       clk_50m;
  logic       rst;
  logic       clken;
  logic       rx;
  logic       rdy;
  logic       rdy_clr;
  logic [7:0] data;

  int unsigned total;
  int unsigned bad;
  int unsigned phase;
  bit          gate;
  bit          freeze;
  logic [7:0]  exp_q[$];

  uart_sim_receiver #(.OVERSAMPLE(16)) dut (
    .clk_50m(clk_50m),
    .rst    (rst),
    .clken  (clken),
    .rx     (rx),
    .rdy    (rdy),
    .rdy_clr(rdy_clr),
    .data   (data)
  );

  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Advance one clock and set clken for the following cycle.
  task automatic tick_clk();
    @(posedge clk_50m);
    #1;
    phase++;
    if (freeze)    clken = 1'b0;
    else if (gate) clken = ((phase % 4) == 0);
    else           clken = 1'b1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) tick_clk();
  endtask

  // Drive one 8N1 frame; abort_bits<10 stops early, clr_last pulses rdy_clr on
  // the final clock of the stop bit, freeze_bit inserts a clken-off pause.
  task automatic send(input logic [7:0] b, input int unsigned per_bit,
                      input bit clr_last, input int unsigned abort_bits,
                      input int unsigned freeze_bit);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int unsigned i = 0; i < 10; i++) begin
      if (i >= abort_bits) break;
      rx = frame[i];
      for (int unsigned j = 0; j < per_bit; j++) begin
        if (i == freeze_bit && j == per_bit / 2) begin
          logic [7:0] held;
          logic       held_rdy;
          held     = data;
          held_rdy = rdy;
          freeze   = 1'b1;
          clken    = 1'b0;
          idle(100);
          check("freeze_data", data, held);
          check("freeze_rdy", {7'd0, rdy}, {7'd0, held_rdy});
          freeze = 1'b0;
        end
        if (clr_last && i == 9 && j == per_bit - 1) rdy_clr = 1'b1;
        tick_clk();
        rdy_clr = 1'b0;
      end
    end
    rx = 1'b1;
  endtask

  task automatic clear_rdy();
    rdy_clr = 1'b1;
    tick_clk();
    rdy_clr = 1'b0;
  endtask

  task automatic monitor();
    logic       prev_rdy;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_rdy  = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk_50m);
      if (!rst && rdy && (!prev_rdy || data != prev_data)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %h want none", data);
        end else begin
          e = exp_q.pop_front();
          check("byte", data, e);
        end
      end
      prev_rdy  = rdy;
      prev_data = data;
    end
  endtask

  initial begin
    total = 0; bad = 0; phase = 0;
    gate = 1'b0; freeze = 1'b0;
    rst = 1'b1; clken = 1'b1; rx = 1'b1; rdy_clr = 1'b0;
    fork
      monitor();
    join_none
    idle(3);
    rst = 1'b0;
    idle(5);
    check("reset_rdy", {7'd0, rdy}, 8'h00);
    check("reset_data", data, 8'h00);

    // Single byte, rdy must be sticky.
    exp_q.push_back(8'h55);
    send(8'h55, 16, 1'b0, 10, 99);
    check("55_rdy", {7'd0, rdy}, 8'h01);
    idle(40);
    check("55_sticky", {7'd0, rdy}, 8'h01);
    check("55_data", data, 8'h55);
    clear_rdy();

    // Clear after A3.
    idle(5);
    exp_q.push_back(8'hA3);
    send(8'hA3, 16, 1'b0, 10, 99);
    idle(3);
    clear_rdy();
    check("clr_rdy", {7'd0, rdy}, 8'h00);
    check("clr_data", data, 8'hA3);

    // Back-to-back, no gap, no clear.
    idle(5);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h0A);
    send(8'h48, 16, 1'b0, 10, 99);
    check("b2b_first", data, 8'h48);
    check("b2b_rdy1", {7'd0, rdy}, 8'h01);
    send(8'h0A, 16, 1'b0, 10, 99);
    check("b2b_second", data, 8'h0A);
    check("b2b_rdy2", {7'd0, rdy}, 8'h01);

    // Reset mid-frame after 4 data bits of FF.
    idle(5);
    send(8'hFF, 16, 1'b0, 5, 99);
    rst = 1'b1;
    tick_clk();
    rst = 1'b0;
    rx  = 1'b1;
    check("rst_rdy", {7'd0, rdy}, 8'h00);
    check("rst_data", data, 8'h00);
    idle(40);
    check("rst_hold", {7'd0, rdy}, 8'h00);
    exp_q.push_back(8'h31);
    send(8'h31, 16, 1'b0, 10, 99);
    check("after_rst", data, 8'h31);

    // Tick gating 1 in 4, with a frozen pause mid-frame.
    idle(5);
    gate = 1'b1;
    idle(4);
    exp_q.push_back(8'hC6);
    send(8'hC6, 64, 1'b0, 10, 4);
    idle(8);
    check("gated_data", data, 8'hC6);
    gate = 1'b0;
    idle(2);

    // rdy_clr on the completion cycle: set wins.
    clear_rdy();
    check("pre7e_rdy", {7'd0, rdy}, 8'h00);
    idle(5);
    exp_q.push_back(8'h7E);
    send(8'h7E, 16, 1'b1, 10, 99);
    check("sim_rdy", {7'd0, rdy}, 8'h01);
    check("sim_data", data, 8'h7E);

    idle(50);
    check("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
